// File: rtl/iopad_seq.sv
// -----------------------------------------------------------------------------
// iopad_seq
// Half-duplex single-wire sequencer sitting upstream of an iopad cell.
// A request shifts out a DW-bit word MSB first. A write then ends the
// transaction. A read releases the pad for TURN_CYC cycles, shifts in a DW-bit
// reply MSB first, and presents it with a one-cycle rsp_valid pulse.
//
// Ports
//   clk           in   rising-edge system clock
//   rst_n         in   asynchronous active-low reset
//   i_req_valid   in   request present
//   o_req_ready   out  request can be accepted (state is IDLE)
//   i_req_data    in   [DW-1:0] word to transmit, MSB first
//   i_req_rd      in   1 = read (TX then RX), 0 = write (TX only)
//   o_rsp_valid   out  one-cycle pulse, o_rsp_data valid
//   o_rsp_data    out  [DW-1:0] last completed RX word, held until next read
//   o_busy        out  high in every state except IDLE
//   o_pad_dout    out  to iopad dout
//   o_pad_dout_en out  to iopad dout_en (1 = this block drives the pad)
//   i_pad_din     in   from iopad din, assumed synchronous to clk
// -----------------------------------------------------------------------------
module iopad_seq #(
   parameter int DW       = 8,
   parameter int TURN_CYC = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_req_valid,
   output logic          o_req_ready,
   input  logic [DW-1:0] i_req_data,
   input  logic          i_req_rd,
   output logic          o_rsp_valid,
   output logic [DW-1:0] o_rsp_data,
   output logic          o_busy,
   output logic          o_pad_dout,
   output logic          o_pad_dout_en,
   input  logic          i_pad_din
);

   localparam int MAXC = (DW > TURN_CYC) ? DW : TURN_CYC;
   localparam int CW   = $clog2(MAXC) + 1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_TX   = 3'd1,
      ST_TURN = 3'd2,
      ST_RX   = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   // The bit currently on the pad lives in r_pad_dout, so the shift register
   // holds only the bits still waiting to go out (MSB = next bit).
   logic [DW-1:0]   r_shift;
   logic [DW-1:0]   w_shift_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic            r_rd;
   logic            w_rd_nxt;
   // The final sample goes straight into the response word, so only DW-1
   // bits of partial reply are ever stored.
   logic [DW-2:0]   r_rx;
   logic [DW-2:0]   w_rx_nxt;
   logic [DW-1:0]   w_rx_word;
   logic            r_pad_dout;
   logic            w_pad_dout_nxt;
   logic            r_pad_dout_en;
   logic            w_pad_dout_en_nxt;
   logic            r_rsp_valid;
   logic            w_rsp_valid_nxt;
   logic [DW-1:0]   r_rsp_data;
   logic [DW-1:0]   w_rsp_data_nxt;

   assign w_rx_word = {r_rx, i_pad_din};

   // Next-state and next-output decode; pad outputs default to released.
   always_comb begin
      w_state_nxt       = r_state;
      w_shift_nxt       = r_shift;
      w_cnt_nxt         = r_cnt;
      w_rd_nxt          = r_rd;
      w_rx_nxt          = r_rx;
      w_pad_dout_nxt    = 1'b0;
      w_pad_dout_en_nxt = 1'b0;
      w_rsp_valid_nxt   = 1'b0;
      w_rsp_data_nxt    = r_rsp_data;
      case (r_state)
         ST_IDLE: begin
            if (i_req_valid) begin
               w_state_nxt       = ST_TX;
               w_pad_dout_en_nxt = 1'b1;
               {w_pad_dout_nxt, w_shift_nxt} = {i_req_data, 1'b0};
               w_cnt_nxt         = CW'(DW - 1);
               w_rd_nxt          = i_req_rd;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_TX: begin
            if (r_cnt == {CW{1'b0}}) begin
               // Last bit ends here; pad is released at this edge.
               if (r_rd) begin
                  w_state_nxt = ST_TURN;
                  w_cnt_nxt   = CW'(TURN_CYC - 1);
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else begin
               w_pad_dout_en_nxt = 1'b1;
               {w_pad_dout_nxt, w_shift_nxt} = {r_shift, 1'b0};
               w_cnt_nxt         = r_cnt - CW'(1);
            end
         end
         ST_TURN: begin
            if (r_cnt == {CW{1'b0}}) begin
               w_state_nxt = ST_RX;
               w_cnt_nxt   = CW'(DW - 1);
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         ST_RX: begin
            w_rx_nxt = w_rx_word[DW-2:0];
            if (r_cnt == {CW{1'b0}}) begin
               w_state_nxt     = ST_DONE;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_data_nxt  = w_rx_word;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset releases the pad without a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_shift       <= {DW{1'b0}};
         r_cnt         <= {CW{1'b0}};
         r_rd          <= 1'b0;
         r_rx          <= {(DW-1){1'b0}};
         r_pad_dout    <= 1'b0;
         r_pad_dout_en <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_data    <= {DW{1'b0}};
      end else begin
         r_state       <= w_state_nxt;
         r_shift       <= w_shift_nxt;
         r_cnt         <= w_cnt_nxt;
         r_rd          <= w_rd_nxt;
         r_rx          <= w_rx_nxt;
         r_pad_dout    <= w_pad_dout_nxt;
         r_pad_dout_en <= w_pad_dout_en_nxt;
         r_rsp_valid   <= w_rsp_valid_nxt;
         r_rsp_data    <= w_rsp_data_nxt;
      end
   end

   assign o_req_ready   = (r_state == ST_IDLE);
   assign o_busy        = (r_state != ST_IDLE);
   assign o_pad_dout    = r_pad_dout;
   assign o_pad_dout_en = r_pad_dout_en;
   assign o_rsp_valid   = r_rsp_valid;
   assign o_rsp_data    = r_rsp_data;

endmodule

// File: tb/tb_iopad_seq.sv
// -----------------------------------------------------------------------------
// tb_iopad_seq
// Scenario bench for iopad_seq (DW=8, TURN_CYC=1). Expected pad bits and
// response words are queued when a request is driven and popped as the pad
// shows activity. Cycle 0 is the cycle whose ending edge accepts a request.
// -----------------------------------------------------------------------------
module tb_iopad_seq;

   localparam int DW       = 8;
   localparam int TURN_CYC = 1;
   localparam int RSP_CYC  = 2*DW + TURN_CYC + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [DW-1:0] req_data = 8'h00;
   logic          req_rd = 1'b0;
   logic          rsp_valid;
   logic [DW-1:0] rsp_data;
   logic          busy;
   logic          pad_dout;
   logic          pad_dout_en;
   logic          pad_din = 1'b0;

   int            n_tests = 0;
   int            n_fail  = 0;

   logic          q_tx[$];
   logic [DW-1:0] q_rsp[$];
   logic          exp_bit;
   logic          exp_en;
   logic [DW-1:0] exp_word;

   iopad_seq #(.DW(DW), .TURN_CYC(TURN_CYC)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_req_valid   (req_valid),
      .o_req_ready   (req_ready),
      .i_req_data    (req_data),
      .i_req_rd      (req_rd),
      .o_rsp_valid   (rsp_valid),
      .o_rsp_data    (rsp_data),
      .o_busy        (busy),
      .o_pad_dout    (pad_dout),
      .o_pad_dout_en (pad_dout_en),
      .i_pad_din     (pad_din)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_tests++; if (pad_dout_en !== 1'b0) begin $display("FAIL reset_dout_en got=%b want=0", pad_dout_en); n_fail++; end
      n_tests++; if (pad_dout !== 1'b0) begin $display("FAIL reset_dout got=%b want=0", pad_dout); n_fail++; end
      n_tests++; if (rsp_valid !== 1'b0) begin $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); n_fail++; end
      n_tests++; if (rsp_data !== 8'h00) begin $display("FAIL reset_rsp_data got=%h want=00", rsp_data); n_fail++; end
      n_tests++; if (busy !== 1'b0) begin $display("FAIL reset_busy got=%b want=0", busy); n_fail++; end
      n_tests++; if (req_ready !== 1'b1) begin $display("FAIL reset_req_ready got=%b want=1", req_ready); n_fail++; end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_tests++; if ((pad_dout_en !== 1'b0) || (busy !== 1'b0)) begin
            $display("FAIL reset_idle en=%b busy=%b want 0/0", pad_dout_en, busy); n_fail++;
         end
      end
   endtask

   task automatic test_write(input logic [DW-1:0] data);
      @(posedge clk); #1;
      req_valid = 1'b1; req_data = data; req_rd = 1'b0;
      for (int i = DW-1; i >= 0; i--) q_tx.push_back(data[i]);
      n_tests++; if (req_ready !== 1'b1) begin $display("FAIL wr_ready_c0 got=%b want=1", req_ready); n_fail++; end
      @(posedge clk); #1;
      req_valid = 1'b0; req_data = ~data; req_rd = 1'b1;
      for (int c = 1; c <= DW+1; c++) begin
         @(negedge clk);
         exp_en = (c <= DW);
         n_tests++; if (pad_dout_en !== exp_en) begin $display("FAIL wr_en c=%0d got=%b want=%b", c, pad_dout_en, exp_en); n_fail++; end
         n_tests++;
         if (pad_dout_en === 1'b1) begin
            if (q_tx.size() == 0) begin $display("FAIL wr_extra_bit c=%0d got=%b want=none", c, pad_dout); n_fail++; end
            else begin
               exp_bit = q_tx.pop_front();
               if (pad_dout !== exp_bit) begin $display("FAIL wr_bit c=%0d got=%b want=%b", c, pad_dout, exp_bit); n_fail++; end
            end
         end else if (pad_dout !== 1'b0) begin
            $display("FAIL wr_dout_idle c=%0d got=%b want=0", c, pad_dout); n_fail++;
         end
         n_tests++; if (rsp_valid !== 1'b0) begin $display("FAIL wr_rsp_valid c=%0d got=%b want=0", c, rsp_valid); n_fail++; end
         n_tests++; if (req_ready !== (c == DW+1)) begin $display("FAIL wr_ready c=%0d got=%b want=%b", c, req_ready, (c == DW+1)); n_fail++; end
      end
      n_tests++; if (q_tx.size() != 0) begin $display("FAIL wr_bits_left got=%0d want=0", q_tx.size()); n_fail++; end
   endtask

   task automatic test_read(input logic [DW-1:0] data, input logic [DW-1:0] din_word);
      @(posedge clk); #1;
      req_valid = 1'b1; req_data = data; req_rd = 1'b1;
      for (int i = DW-1; i >= 0; i--) q_tx.push_back(data[i]);
      q_rsp.push_back(din_word);
      n_tests++; if (req_ready !== 1'b1) begin $display("FAIL rd_ready_c0 got=%b want=1", req_ready); n_fail++; end
      @(posedge clk); #1;
      req_valid = 1'b0; req_data = ~data; req_rd = 1'b0;
      for (int c = 1; c <= RSP_CYC+1; c++) begin
         @(negedge clk);
         exp_en = (c <= DW);
         n_tests++; if (pad_dout_en !== exp_en) begin $display("FAIL rd_en c=%0d got=%b want=%b", c, pad_dout_en, exp_en); n_fail++; end
         n_tests++;
         if (pad_dout_en === 1'b1) begin
            if (q_tx.size() == 0) begin $display("FAIL rd_extra_bit c=%0d got=%b want=none", c, pad_dout); n_fail++; end
            else begin
               exp_bit = q_tx.pop_front();
               if (pad_dout !== exp_bit) begin $display("FAIL rd_bit c=%0d got=%b want=%b", c, pad_dout, exp_bit); n_fail++; end
            end
         end else if (pad_dout !== 1'b0) begin
            $display("FAIL rd_dout_idle c=%0d got=%b want=0", c, pad_dout); n_fail++;
         end
         n_tests++; if (rsp_valid !== (c == RSP_CYC)) begin $display("FAIL rd_rsp_valid c=%0d got=%b want=%b", c, rsp_valid, (c == RSP_CYC)); n_fail++; end
         if (rsp_valid === 1'b1) begin
            n_tests++;
            if (q_rsp.size() == 0) begin $display("FAIL rd_extra_rsp c=%0d got=%h want=none", c, rsp_data); n_fail++; end
            else begin
               exp_word = q_rsp.pop_front();
               if (rsp_data !== exp_word) begin $display("FAIL rd_rsp_data c=%0d got=%h want=%h", c, rsp_data, exp_word); n_fail++; end
            end
         end
         if (c == RSP_CYC+1) begin
            n_tests++; if (rsp_data !== din_word) begin $display("FAIL rd_rsp_hold got=%h want=%h", rsp_data, din_word); n_fail++; end
         end
         n_tests++; if (busy !== (c <= RSP_CYC)) begin $display("FAIL rd_busy c=%0d got=%b want=%b", c, busy, (c <= RSP_CYC)); n_fail++; end
         n_tests++; if (req_ready !== (c == RSP_CYC+1)) begin $display("FAIL rd_ready c=%0d got=%b want=%b", c, req_ready, (c == RSP_CYC+1)); n_fail++; end
         // Reply bit for the RX window is presented for the edge ending this cycle.
         if ((c >= DW+TURN_CYC+1) && (c <= 2*DW+TURN_CYC)) pad_din = din_word[2*DW+TURN_CYC-c];
         else pad_din = 1'b0;
      end
      n_tests++; if ((q_tx.size() != 0) || (q_rsp.size() != 0)) begin
         $display("FAIL rd_queue_left got=%0d/%0d want=0/0", q_tx.size(), q_rsp.size()); n_fail++;
      end
   endtask

   task automatic test_back_to_back();
      @(posedge clk); #1;
      req_valid = 1'b1; req_data = 8'hFF; req_rd = 1'b0;
      for (int i = 0; i < DW; i++) q_tx.push_back(1'b1);
      for (int i = 0; i < DW; i++) q_tx.push_back(1'b0);
      @(posedge clk); #1;
      req_data = 8'h00;
      for (int c = 1; c <= 2*DW+2; c++) begin
         @(negedge clk);
         exp_en = (c <= DW) || ((c >= DW+2) && (c <= 2*DW+1));
         n_tests++; if (pad_dout_en !== exp_en) begin $display("FAIL b2b_en c=%0d got=%b want=%b", c, pad_dout_en, exp_en); n_fail++; end
         if (pad_dout_en === 1'b1) begin
            n_tests++;
            if (q_tx.size() == 0) begin $display("FAIL b2b_extra_bit c=%0d got=%b want=none", c, pad_dout); n_fail++; end
            else begin
               exp_bit = q_tx.pop_front();
               if (pad_dout !== exp_bit) begin $display("FAIL b2b_bit c=%0d got=%b want=%b", c, pad_dout, exp_bit); n_fail++; end
            end
         end
         n_tests++; if (req_ready !== ((c == DW+1) || (c == 2*DW+2))) begin
            $display("FAIL b2b_ready c=%0d got=%b want=%b", c, req_ready, ((c == DW+1) || (c == 2*DW+2))); n_fail++;
         end
         if (c == DW+1) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
         end
      end
      n_tests++; if (q_tx.size() != 0) begin $display("FAIL b2b_bits_left got=%0d want=0", q_tx.size()); n_fail++; end
   endtask

   task automatic test_busy_ignore();
      @(posedge clk); #1;
      req_valid = 1'b1; req_data = 8'hC3; req_rd = 1'b0;
      for (int i = DW-1; i >= 0; i--) q_tx.push_back(req_data[i]);
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 1; c <= DW+4; c++) begin
         @(negedge clk);
         exp_en = (c <= DW);
         n_tests++; if (pad_dout_en !== exp_en) begin $display("FAIL ign_en c=%0d got=%b want=%b", c, pad_dout_en, exp_en); n_fail++; end
         if (pad_dout_en === 1'b1) begin
            n_tests++;
            if (q_tx.size() == 0) begin $display("FAIL ign_extra_bit c=%0d got=%b want=none", c, pad_dout); n_fail++; end
            else begin
               exp_bit = q_tx.pop_front();
               if (pad_dout !== exp_bit) begin $display("FAIL ign_bit c=%0d got=%b want=%b", c, pad_dout, exp_bit); n_fail++; end
            end
         end
         n_tests++; if (busy !== (c <= DW)) begin $display("FAIL ign_busy c=%0d got=%b want=%b", c, busy, (c <= DW)); n_fail++; end
         if (c == 3) begin
            @(posedge clk); #1;
            req_valid = 1'b1; req_data = 8'h11;
         end else if (c == 4) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
         end
      end
      n_tests++; if (q_tx.size() != 0) begin $display("FAIL ign_bits_left got=%0d want=0", q_tx.size()); n_fail++; end
   endtask

   task automatic test_reset_abort();
      logic [DW-1:0] din_word;
      din_word = 8'h5A;
      @(posedge clk); #1;
      req_valid = 1'b1; req_data = 8'h96; req_rd = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 1; c <= 13; c++) begin
         @(negedge clk);
         if (c == 13) begin
            n_tests++; if (busy !== 1'b1) begin $display("FAIL abort_pre_busy got=%b want=1", busy); n_fail++; end
            rst_n = 1'b0;
            #1;
            n_tests++; if (pad_dout_en !== 1'b0) begin $display("FAIL abort_en got=%b want=0", pad_dout_en); n_fail++; end
            n_tests++; if (busy !== 1'b0) begin $display("FAIL abort_busy got=%b want=0", busy); n_fail++; end
            n_tests++; if (req_ready !== 1'b1) begin $display("FAIL abort_ready got=%b want=1", req_ready); n_fail++; end
            n_tests++; if (rsp_data !== 8'h00) begin $display("FAIL abort_rsp_data got=%h want=00", rsp_data); n_fail++; end
         end else if (c >= DW+TURN_CYC+1) begin
            pad_din = din_word[2*DW+TURN_CYC-c];
         end
      end
      pad_din = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         n_tests++; if ((rsp_valid !== 1'b0) || (pad_dout_en !== 1'b0)) begin
            $display("FAIL abort_quiet rsp_valid=%b en=%b want 0/0", rsp_valid, pad_dout_en); n_fail++;
         end
      end
      rst_n = 1'b1;
      q_tx.delete();
      q_rsp.delete();
      test_read(8'hC9, 8'h81);
   endtask

   initial begin
      test_reset();
      test_write(8'hA5);
      test_read(8'h3C, 8'h5A);
      test_back_to_back();
      test_busy_ignore();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Absolute time limit so a stalled scenario still ends the run.
   initial begin
      #200000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "timeout");
   end

endmodule
